p_dot_seq: RTL and testbench
============================

P_DOT_SEQ -- requirements
Module: p_dot_seq

Interface
REQ-001 SHALL have parameter I1_CONF, default {FXP, sign 1, prec 8, frac 3}, dconf_t of operand 1.
REQ-002 SHALL have parameter I2_CONF, default {FXP, sign 1, prec 8, frac 3}, dconf_t of operand 2.
REQ-003 SHALL have parameter O_CONF, default {FXP, sign I1|I2, prec I1+I2, frac I1+I2}, dconf_t of product and accumulator.
REQ-004 SHALL have parameter LEN_W, default 8, width of the element-count field.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 reset_  input  1  asynchronous active-low reset.
REQ-008 start  input  1  begin a dot product; honoured in IDLE only.
REQ-009 len  input  LEN_W  element count, sampled with start.
REQ-010 in_valid  input  1  operand pair valid.
REQ-011 in_ready  output  1  block accepts operand pair.
REQ-012 in1  input  I1_CONF.prec  operand 1.
REQ-013 in2  input  I2_CONF.prec  operand 2.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 out  output  O_CONF.prec  accumulated result.
REQ-017 ovf / udf / rounded  output  1 each  sticky flags for the current job.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: on start=1, latch cnt=len, clear acc, preg, pvalid and flags; go to RUN if len!=0, else go to DONE with acc=0.
REQ-021 RUN: in_ready=1; on in_valid&in_ready, register the p_mult product in preg, set pvalid=1 and decrement cnt; the transfer with cnt==1 moves the FSM to DRAIN.
REQ-022 in_valid low in RUN: no transfer; pvalid=0 on the next edge; cnt holds.
REQ-023 Each edge with pvalid=1: acc <= sat(acc+preg). One product is accumulated per cycle, so back-to-back input has no stall.
REQ-024 DRAIN: in_ready=0; accumulate the final preg; go to DONE on the next edge. out_valid is high exactly 2 edges after the edge that accepted the last element.
REQ-025 DONE: out_valid=1, out=acc, flags held stable; on out_ready=1 go to IDLE; out_valid drops on that edge.
REQ-026 start in RUN, DRAIN or DONE SHALL be ignored. in_valid outside RUN SHALL be ignored.
REQ-027 Saturation, signed O_CONF: clamp to max/min representable value and set ovf. Unsigned O_CONF: clamp to all-ones and set ovf.
REQ-028 p_mult udf, ovf and rounded on an accepted transfer SHALL be ORed into the sticky flags.
REQ-029 Flags clear only on an accepted start.
REQ-030 in_ready and out_valid SHALL be decoded from FSM state only, with no combinational path from in_valid or out_ready.

Reset
REQ-031 reset_ low SHALL immediately force: state IDLE; acc, preg and cnt to 0; pvalid=0; in_ready=0; out_valid=0; out=0; all flags 0; busy=0.
REQ-032 Reset asserted mid-job SHALL abandon the job; after release the block idles until a new start.

Structure
REQ-033 State enum p_dot_state_t SHALL live in the shared perceptron package next to dconf_t.
REQ-034 The saturation max/min helpers SHALL live in the shared perceptron package next to dconf_t.
REQ-035 SHALL instantiate exactly one existing p_mult (I1_CONF, I2_CONF, O_CONF) as its only sub-module.
REQ-036 Accumulator width and frac SHALL equal O_CONF; no rescaling between preg and acc.

Verification (defaults; out is 16b, frac 6)
REQ-037 len=2, pairs (3.5, 2.0) and (1.0, 1.0) back-to-back -> out=8.0 (16'h0200), flags 0, out_valid 2 edges after the 2nd transfer.
REQ-038 len=0 -> DONE one edge after start, out=16'h0000, flags 0, in_ready never high.
REQ-039 len=4, pairs all (15.75, 15.75) -> out=16'h7FFF, ovf=1.
REQ-040 len=3, in_valid with gaps, out_ready held low 5 cycles -> out and flags stable throughout; start pulses during the job ignored; IDLE after out_ready.
REQ-041 reset_ low after 2 of len=5 transfers -> all outputs 0 at once; a new len=1 job with pair (2.0, 2.0) -> out=4.0 (16'h0100).
REQ-042 Random: 1000 jobs with random len and operands; results SHALL match a real-valued model whenever all flags are 0.

Source files
------------

// File: rtl/p_dot_seq_pkg.sv
// Shared perceptron package: number-format descriptor, dot-product sequencer
// state encoding and the saturation bound helpers used by the datapath.
package p_dot_seq_pkg;

   typedef enum logic [1:0] {
      FXP = 2'd0,
      FLP = 2'd1
   } dtype_t;

   // Number format: signedness, total bit width and fractional bit count.
   typedef struct packed {
      dtype_t      dtype;
      logic        sign;
      int unsigned prec;
      int unsigned frac;
   } dconf_t;

   localparam dconf_t FXP_S8_F3 = '{dtype: FXP, sign: 1'b1, prec: 8, frac: 3};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } p_dot_state_t;

   // Largest / smallest raw integer representable in format c (prec <= 63).
   function automatic longint sat_max(dconf_t c);
      return c.sign ? (64'sd1 <<< (c.prec - 1)) - 64'sd1
                    : (64'sd1 <<< c.prec) - 64'sd1;
   endfunction

   function automatic longint sat_min(dconf_t c);
      return c.sign ? -(64'sd1 <<< (c.prec - 1)) : 64'sd0;
   endfunction

endpackage

// File: rtl/p_dot_seq_mult.sv
// p_mult: combinational fixed-point multiplier with format conversion.
// The exact product is aligned to O_CONF.frac (truncating toward minus
// infinity when bits are dropped) and saturated to O_CONF.prec.
// Ports:
//   in1     operand 1, I1_CONF format
//   in2     operand 2, I2_CONF format
//   out     product, O_CONF format
//   ovf     product clamped to the format maximum
//   udf     product clamped to the format minimum
//   rounded nonzero fraction bits were discarded
module p_mult
   import p_dot_seq_pkg::*;
#(
   parameter dconf_t I1_CONF = FXP_S8_F3,
   parameter dconf_t I2_CONF = FXP_S8_F3,
   parameter dconf_t O_CONF  = '{dtype: FXP, sign: I1_CONF.sign | I2_CONF.sign,
                                 prec: I1_CONF.prec + I2_CONF.prec,
                                 frac: I1_CONF.frac + I2_CONF.frac}
) (
   input  logic [I1_CONF.prec-1:0] in1,
   input  logic [I2_CONF.prec-1:0] in2,
   output logic [O_CONF.prec-1:0]  out,
   output logic                    ovf,
   output logic                    udf,
   output logic                    rounded
);

   localparam int     PF    = int'(I1_CONF.frac + I2_CONF.frac);
   localparam int     OF    = int'(O_CONF.frac);
   localparam int     SHR   = (PF > OF) ? PF - OF : 0;
   localparam int     SHL   = (OF > PF) ? OF - PF : 0;
   localparam longint MASK  = (64'sd1 <<< SHR) - 64'sd1;
   localparam longint MAXV  = sat_max(O_CONF);
   localparam longint MINV  = sat_min(O_CONF);

   longint a_ext;
   longint b_ext;
   longint prod;
   longint aligned;

   always_comb begin
      a_ext   = I1_CONF.sign ? longint'(signed'(in1)) : longint'(in1);
      b_ext   = I2_CONF.sign ? longint'(signed'(in2)) : longint'(in2);
      prod    = a_ext * b_ext;
      aligned = (prod >>> SHR) <<< SHL;
      rounded = (prod & MASK) != 64'sd0;
      ovf     = aligned > MAXV;
      udf     = aligned < MINV;
      if (ovf)
         out = MAXV[O_CONF.prec-1:0];
      else if (udf)
         out = MINV[O_CONF.prec-1:0];
      else
         out = aligned[O_CONF.prec-1:0];
   end

endmodule

// File: rtl/p_dot_seq.sv
// p_dot_seq: sequential saturating dot product. Operand pairs stream in
// through a valid/ready handshake, each product is registered and then
// accumulated one cycle later, and the result is held until consumed.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet
//   RUN   | accepting operand pairs, cnt counts down remaining elements
//   DRAIN | no new input; last registered product is accumulated
//   DONE  | result and sticky flags presented until out_ready
//
// Ports:
//   clk, reset_            clock, async active-low reset
//   start, len             job request and element count (IDLE only)
//   in_valid/in_ready      operand handshake, in1/in2 operands
//   out_valid/out_ready    result handshake, out accumulated result
//   ovf, udf, rounded      sticky flags for the current job
//   busy                   any state other than IDLE
module p_dot_seq
   import p_dot_seq_pkg::*;
#(
   parameter dconf_t I1_CONF = FXP_S8_F3,
   parameter dconf_t I2_CONF = FXP_S8_F3,
   parameter dconf_t O_CONF  = '{dtype: FXP, sign: I1_CONF.sign | I2_CONF.sign,
                                 prec: I1_CONF.prec + I2_CONF.prec,
                                 frac: I1_CONF.frac + I2_CONF.frac},
   parameter int     LEN_W   = 8
) (
   input  logic                    clk,
   input  logic                    reset_,
   input  logic                    start,
   input  logic [LEN_W-1:0]        len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [I1_CONF.prec-1:0] in1,
   input  logic [I2_CONF.prec-1:0] in2,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [O_CONF.prec-1:0]  out,
   output logic                    ovf,
   output logic                    udf,
   output logic                    rounded,
   output logic                    busy
);

   localparam int     OW      = int'(O_CONF.prec);
   localparam longint ACC_MAX = sat_max(O_CONF);
   localparam longint ACC_MIN = sat_min(O_CONF);

   p_dot_state_t   state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [OW-1:0]  acc_q, acc_d;
   logic [OW-1:0]  preg_q, preg_d;
   logic           pvalid_q, pvalid_d;
   logic           ovf_q, ovf_d;
   logic           udf_q, udf_d;
   logic           rnd_q, rnd_d;

   logic [OW-1:0]  m_out;
   logic           m_ovf;
   logic           m_udf;
   logic           m_rnd;

   longint         sum;
   logic           sum_hi;
   logic           sum_lo;
   logic [OW-1:0]  sum_sat;

   p_mult #(
      .I1_CONF (I1_CONF),
      .I2_CONF (I2_CONF),
      .O_CONF  (O_CONF)
   ) u_mult (
      .in1     (in1),
      .in2     (in2),
      .out     (m_out),
      .ovf     (m_ovf),
      .udf     (m_udf),
      .rounded (m_rnd)
   );

   // acc and preg share O_CONF, so the sum needs no alignment; both
   // saturation directions report as ovf.
   always_comb begin
      sum = O_CONF.sign ? longint'(signed'(acc_q)) + longint'(signed'(preg_q))
                        : longint'(acc_q) + longint'(preg_q);
      sum_hi = sum > ACC_MAX;
      sum_lo = sum < ACC_MIN;
      if (sum_hi)
         sum_sat = ACC_MAX[OW-1:0];
      else if (sum_lo)
         sum_sat = ACC_MIN[OW-1:0];
      else
         sum_sat = sum[OW-1:0];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      preg_d   = preg_q;
      pvalid_d = 1'b0;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      rnd_d    = rnd_q;

      if (pvalid_q) begin
         acc_d = sum_sat;
         ovf_d = ovf_q | sum_hi | sum_lo;
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = len;
               acc_d   = '0;
               preg_d  = '0;
               ovf_d   = 1'b0;
               udf_d   = 1'b0;
               rnd_d   = 1'b0;
               state_d = (len != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (in_valid) begin
               preg_d   = m_out;
               pvalid_d = 1'b1;
               cnt_d    = cnt_q - LEN_W'(1);
               ovf_d    = ovf_d | m_ovf;
               udf_d    = udf_q | m_udf;
               rnd_d    = rnd_q | m_rnd;
               if (cnt_q == LEN_W'(1))
                  state_d = DRAIN;
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         preg_q   <= '0;
         pvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         rnd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         preg_q   <= preg_d;
         pvalid_q <= pvalid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         rnd_q    <= rnd_d;
      end
   end

   assign in_ready  = (state_q == RUN);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out       = acc_q;
   assign ovf       = ovf_q;
   assign udf       = udf_q;
   assign rounded   = rnd_q;

endmodule

// File: tb/tb_p_dot_seq.sv
// Bench for p_dot_seq with default formats: s8.3 operands, s16.6 result.
module tb_p_dot_seq;

   logic        clk       = 1'b0;
   logic        reset_    = 1'b1;
   logic        start     = 1'b0;
   logic [7:0]  len       = '0;
   logic        in_valid  = 1'b0;
   logic [7:0]  in1       = '0;
   logic [7:0]  in2       = '0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out;
   logic        ovf;
   logic        udf;
   logic        rounded;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] opa [16];
   logic [7:0] opb [16];

   typedef struct packed {
      logic [7:0]  n;
      logic [31:0] a;     // element i in a[8*i +: 8]
      logic [31:0] b;
      logic [15:0] eo;
      logic        eovf;
   } vec_t;

   vec_t tbl [8];

   p_dot_seq dut (
      .clk       (clk),
      .reset_    (reset_),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .ovf       (ovf),
      .udf       (udf),
      .rounded   (rounded),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h", nm, act, exp);
      end
   endtask

   // Real-valued reference: each product is exact in s16.6, the running sum
   // is clamped to the representable range after every addition.
   task automatic model(input int n, output logic [15:0] eo, output logic eovf);
      real s;
      real p;
      s    = 0.0;
      eovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         p = (real'($signed(opa[i])) / 8.0) * (real'($signed(opb[i])) / 8.0);
         s = s + p;
         if (s > 32767.0 / 64.0) begin
            s    = 32767.0 / 64.0;
            eovf = 1'b1;
         end else if (s < -512.0) begin
            s    = -512.0;
            eovf = 1'b1;
         end
      end
      eo = 16'($rtoi(s * 64.0));
   endtask

   // One complete job from IDLE back to IDLE. gap_pct throttles in_valid,
   // hold keeps out_ready low for that many cycles, poke sprinkles start and
   // in_valid pulses where they must be ignored.
   task automatic run_job(input int n, input int gap_pct, input int hold, input bit poke,
                          input logic [15:0] eo, input logic eovf);
      int  i;
      int  guard;
      int  lat;
      bit  acc_now;
      i     = 0;
      guard = 0;
      lat   = 0;
      start = 1'b1;
      len   = 8'(n);
      tick();
      start = 1'b0;
      while (i < n && guard < 1000) begin
         in_valid = ($urandom_range(0, 99) >= gap_pct);
         in1      = opa[i];
         in2      = opb[i];
         if (poke) begin
            start = 1'($urandom_range(0, 1));
            len   = 8'($urandom);
         end
         acc_now = in_valid && in_ready;
         tick();
         guard++;
         if (acc_now) begin
            i++;
            if (i == n) lat = 1;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("xfer_count", i, n);
      guard = 0;
      while (!out_valid && guard < 50) begin
         if (poke) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
         end
         tick();
         lat++;
         guard++;
      end
      chk("out_valid_rise", out_valid, 1);
      chk("done_latency", lat, (n > 0) ? 2 : 0);
      for (int k = 0; k < hold; k++) begin
         chk("hold_out", out, eo);
         chk("hold_ovf", ovf, eovf);
         chk("hold_valid", out_valid, 1);
         if (poke) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
         end
         tick();
      end
      start    = 1'b0;
      in_valid = 1'b0;
      chk("out", out, eo);
      chk("ovf", ovf, eovf);
      chk("udf", udf, 0);
      chk("rounded", rounded, 0);
      chk("busy_done", busy, 1);
      chk("in_ready_done", in_ready, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      logic [15:0] eo;
      logic        eovf;
      int          n;

      tbl[0] = '{n: 8'd2, a: 32'h0000_081C, b: 32'h0000_0810, eo: 16'h0200, eovf: 1'b0};
      tbl[1] = '{n: 8'd0, a: 32'h0,         b: 32'h0,         eo: 16'h0000, eovf: 1'b0};
      tbl[2] = '{n: 8'd4, a: 32'h7E7E_7E7E, b: 32'h7E7E_7E7E, eo: 16'h7FFF, eovf: 1'b1};
      tbl[3] = '{n: 8'd2, a: 32'h0000_04F8, b: 32'h0000_0410, eo: 16'hFF90, eovf: 1'b0};
      tbl[4] = '{n: 8'd4, a: 32'h8080_8080, b: 32'h7F7F_7F7F, eo: 16'h8000, eovf: 1'b1};
      tbl[5] = '{n: 8'd1, a: 32'h0000_0080, b: 32'h0000_0080, eo: 16'h4000, eovf: 1'b0};
      tbl[6] = '{n: 8'd3, a: 32'h0080_7E7E, b: 32'h007F_7E7E, eo: 16'h3C88, eovf: 1'b0};
      tbl[7] = '{n: 8'd4, a: 32'h807E_7E7E, b: 32'h7F7E_7E7E, eo: 16'h407F, eovf: 1'b1};

      // reset values
      #1 reset_ = 1'b0;
      #2;
      chk("rst_out", out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {ovf, udf, rounded}, 0);
      repeat (2) @(posedge clk);
      #1 reset_ = 1'b1;
      tick();

      // table vectors, back-to-back input
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 4; i++) begin
            opa[i] = tbl[k].a[8*i +: 8];
            opb[i] = tbl[k].b[8*i +: 8];
         end
         run_job(int'(tbl[k].n), 0, 0, 1'b0, tbl[k].eo, tbl[k].eovf);
      end

      // len = 0: straight to DONE, in_ready never raised
      start = 1'b1;
      len   = 8'd0;
      in_valid = 1'b1;
      tick();
      start = 1'b0;
      chk("len0_in_ready", in_ready, 0);
      chk("len0_out_valid", out_valid, 1);
      chk("len0_out", out, 0);
      tick();
      chk("len0_in_ready2", in_ready, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("len0_idle", busy, 0);

      // gapped input, ignored start pulses, out_ready held off 5 cycles
      opa[0] = 8'h08; opb[0] = 8'h0C;
      opa[1] = 8'h10; opb[1] = 8'hFC;
      opa[2] = 8'h02; opb[2] = 8'h20;
      run_job(3, 50, 5, 1'b1, 16'h0060, 1'b0);

      // reset in the middle of a len=5 job
      start = 1'b1;
      len   = 8'd5;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in1      = 8'h08;
      in2      = 8'h08;
      tick();
      tick();
      in_valid = 1'b0;
      chk("mid_out_before_rst", out, 16'h0040);
      chk("mid_busy_before_rst", busy, 1);
      reset_ = 1'b0;
      #1;
      chk("mid_rst_out", out, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_flags", {ovf, udf, rounded}, 0);
      @(posedge clk);
      #2 reset_ = 1'b1;
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      chk("post_rst_idle", busy, 0);
      chk("post_rst_in_ready", in_ready, 0);
      opa[0] = 8'h10;
      opb[0] = 8'h10;
      run_job(1, 0, 0, 1'b0, 16'h0100, 1'b0);

      // randomized jobs against the real-valued model
      for (int j = 0; j < 1000; j++) begin
         n = $urandom_range(0, 8);
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
               0:       begin opa[i] = 8'($urandom_range(112, 127)); opb[i] = 8'($urandom_range(112, 127)); end
               1:       begin opa[i] = 8'($urandom_range(128, 143)); opb[i] = 8'($urandom_range(112, 127)); end
               default: begin opa[i] = 8'($urandom);                opb[i] = 8'($urandom);                end
            endcase
         end
         model(n, eo, eovf);
         run_job(n, $urandom_range(0, 60), $urandom_range(0, 3), 1'($urandom_range(0, 1)), eo, eovf);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
